// File: rtl/fifo_stream_arbiter.sv
// Round-robin merge of CHANNELS first-word-fall-through FIFOs into one FWFT stream.
// The grant is registered, bursts are bounded, and ch0 can preempt at word boundaries.
module fifo_stream_arbiter #(
    parameter int unsigned CHANNELS  = 5,
    parameter int unsigned DSIZE     = 32,
    parameter int unsigned MAX_BURST = 16,
    localparam int unsigned IdxW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      BUS_CLK,
    input  logic                      BUS_RST,
    input  logic [CHANNELS-1:0]       CH_EN,
    input  logic                      PREEMPT_REQ,
    input  logic [CHANNELS-1:0]       CH_EMPTY,
    input  logic [CHANNELS*DSIZE-1:0] CH_DATA,
    output logic [CHANNELS-1:0]       CH_READ,
    input  logic                      OUT_READ,
    output logic                      OUT_EMPTY,
    output logic [DSIZE-1:0]          OUT_DATA,
    output logic                      GRANT_VALID,
    output logic [IdxW-1:0]           GRANT_IDX,
    output logic [31:0]               WORD_CNT
);

    localparam int unsigned BurstW    = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int unsigned BurstLast = (MAX_BURST > 0) ? MAX_BURST - 1 : 0;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     grant_idx_q, grant_idx_d;
    logic                grant_valid_q, grant_valid_d;
    logic [IdxW-1:0]     rr_q, rr_d;
    logic [BurstW-1:0]   burst_q, burst_d;
    logic [31:0]         word_cnt_q, word_cnt_d;

    logic [CHANNELS-1:0] req;
    logic [IdxW-1:0]     winner;
    logic                found;
    logic                brk;
    logic                pop;

    assign req = CH_EN & ~CH_EMPTY;

    // Preempt picks ch0 outright; otherwise scan upward from rr+1 with wrap-around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        if (PREEMPT_REQ && req[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 1; k <= int'(CHANNELS); k++) begin
                if (!found && req[(int'(rr_q) + k) % int'(CHANNELS)]) begin
                    found  = 1'b1;
                    winner = IdxW'((int'(rr_q) + k) % int'(CHANNELS));
                end
            end
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q       <= StIdle;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            rr_q          <= IdxW'(CHANNELS - 1);
            burst_q       <= '0;
            word_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            rr_q          <= rr_d;
            burst_q       <= burst_d;
            word_cnt_q    <= word_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        rr_d          = rr_q;
        burst_d       = burst_q;
        word_cnt_d    = pop ? word_cnt_q + 32'd1 : word_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d       = StGrant;
                    grant_idx_d   = winner;
                    grant_valid_d = 1'b1;
                    rr_d          = winner;
                    burst_d       = '0;
                end
            end
            StGrant: begin
                if (pop) begin
                    burst_d = burst_q + 1'b1;
                end
                if (OUT_EMPTY ||
                    (pop && (MAX_BURST != 0) && (burst_q == BurstW'(BurstLast)))) begin
                    state_d       = StIdle;
                    grant_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A preempt blanks the stream for one cycle so no word is popped mid-handover.
    always_comb begin
        OUT_EMPTY = 1'b1;
        OUT_DATA  = '0;
        CH_READ   = '0;
        brk       = 1'b0;
        pop       = 1'b0;
        if (state_q == StGrant) begin
            brk       = PREEMPT_REQ && (grant_idx_q != '0) && req[0];
            OUT_EMPTY = CH_EMPTY[grant_idx_q] | ~CH_EN[grant_idx_q] | brk;
            OUT_DATA  = CH_DATA[grant_idx_q*DSIZE +: DSIZE];
            pop       = OUT_READ & ~OUT_EMPTY;
            CH_READ[grant_idx_q] = pop;
        end
    end

    assign GRANT_VALID = grant_valid_q;
    assign GRANT_IDX   = grant_idx_q;
    assign WORD_CNT    = word_cnt_q;

endmodule

// File: tb/tb_fifo_stream_arbiter.sv
// Scoreboard bench: FWFT FIFO models feed two arbiters (MAX_BURST=4 and MAX_BURST=0);
// every popped word is compared against the expected-order queue.
module tb_fifo_stream_arbiter;

    localparam int CH = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [CH-1:0]    ch_en, ch_empty, ch_read;
    logic [CH*DW-1:0] ch_data;
    logic             preempt, out_read, out_empty, grant_valid;
    logic [DW-1:0]    out_data;
    logic [2:0]       grant_idx;
    logic [31:0]      word_cnt;

    logic [CH-1:0]    b_ch_en, b_ch_empty, b_ch_read;
    logic [CH*DW-1:0] b_ch_data;
    logic             b_preempt, b_out_read, b_out_empty, b_grant_valid;
    logic [DW-1:0]    b_out_data;
    logic [2:0]       b_grant_idx;
    logic [31:0]      b_word_cnt;

    fifo_stream_arbiter #(.CHANNELS(CH), .DSIZE(DW), .MAX_BURST(4)) dut (
        .BUS_CLK(clk), .BUS_RST(rst), .CH_EN(ch_en), .PREEMPT_REQ(preempt),
        .CH_EMPTY(ch_empty), .CH_DATA(ch_data), .CH_READ(ch_read), .OUT_READ(out_read),
        .OUT_EMPTY(out_empty), .OUT_DATA(out_data), .GRANT_VALID(grant_valid),
        .GRANT_IDX(grant_idx), .WORD_CNT(word_cnt)
    );

    fifo_stream_arbiter #(.CHANNELS(CH), .DSIZE(DW), .MAX_BURST(0)) dut_b (
        .BUS_CLK(clk), .BUS_RST(rst), .CH_EN(b_ch_en), .PREEMPT_REQ(b_preempt),
        .CH_EMPTY(b_ch_empty), .CH_DATA(b_ch_data), .CH_READ(b_ch_read),
        .OUT_READ(b_out_read), .OUT_EMPTY(b_out_empty), .OUT_DATA(b_out_data),
        .GRANT_VALID(b_grant_valid), .GRANT_IDX(b_grant_idx), .WORD_CNT(b_word_cnt)
    );

    logic [31:0] fq [CH][$];
    logic [31:0] sb [$];
    logic [31:0] sb_b [$];
    logic [CH-1:0] pend_rd = '0;
    logic [CH-1:0] b_pend_rd = '0;
    int checks = 0;
    int errors = 0;
    int b_cnt = 0;
    int b_total = 0;
    int b_grants = 0;
    logic b_gv_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int c, input int n);
        return (32'(c) << 24) | 32'(n);
    endfunction

    function automatic void refresh();
        for (int i = 0; i < CH; i++) begin
            ch_empty[i] = (fq[i].size() == 0);
            ch_data[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
        b_ch_empty = {(b_cnt >= b_total), 4'b1111};
        b_ch_data = '0;
        if (b_cnt < b_total) b_ch_data[4*DW +: DW] = 32'hB000_0000 + 32'(b_cnt);
    endfunction

    task automatic push_fifo(input int c, input int n, input bit expect_out);
        fq[c].push_back(word(c, n));
        if (expect_out) sb.push_back(word(c, n));
        refresh();
    endtask

    task automatic wait_cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain(input string tag, input int bound);
        for (int n = 0; n < bound && sb.size() != 0; n++) wait_cyc();
        check_eq(tag, 64'(sb.size()), 0);
        wait_cyc(4);
    endtask

    // Output monitor: mid-cycle, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            pend_rd = '0;
            b_pend_rd = '0;
        end else begin
            if (out_read && !out_empty) begin
                check_eq("a_pop_expected", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("a_data", 64'(out_data), 64'(e));
                    check_eq("a_grant_idx", 64'(grant_idx), 64'(e[31:24]));
                    check_eq("a_ch_read", 64'(ch_read), 64'(1) << e[31:24]);
                end
            end else begin
                check_eq("a_no_read", 64'(ch_read), 0);
            end
            if (b_out_read && !b_out_empty) begin
                check_eq("b_pop_expected", 64'(sb_b.size() != 0), 1);
                if (sb_b.size() != 0) begin
                    e = sb_b.pop_front();
                    check_eq("b_data", 64'(b_out_data), 64'(e));
                end
            end else begin
                check_eq("b_read_gated", 64'(b_ch_read), 0);
            end
            if (b_grant_valid && !b_gv_prev) b_grants++;
            b_gv_prev = b_grant_valid;
            pend_rd = ch_read;
            b_pend_rd = b_ch_read;
        end
    end

    // FIFO models commit the pops the DUT made at this edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < CH; i++) begin
            if (pend_rd[i] && fq[i].size() != 0) fq[i].delete(0);
        end
        if (b_pend_rd[4]) b_cnt++;
        pend_rd = '0;
        b_pend_rd = '0;
        refresh();
    end

    initial begin
        ch_en = '1;
        preempt = 1'b0;
        out_read = 1'b0;
        b_ch_en = '1;
        b_preempt = 1'b0;
        b_out_read = 1'b0;
        refresh();

        // Reset state with every FIFO empty
        #12;
        check_eq("rst_out_empty", 64'(out_empty), 1);
        check_eq("rst_ch_read", 64'(ch_read), 0);
        check_eq("rst_word_cnt", 64'(word_cnt), 0);
        check_eq("rst_grant_valid", 64'(grant_valid), 0);
        check_eq("rst_grant_idx", 64'(grant_idx), 0);
        wait_cyc();
        rst = 1'b0;
        wait_cyc(3);
        check_eq("idle_out_empty", 64'(out_empty), 1);
        check_eq("idle_grant_valid", 64'(grant_valid), 0);

        // Round robin over ch1..ch3, 10 words each, bursts of 4
        out_read = 1'b1;
        for (int c = 1; c <= 3; c++)
            for (int n = 0; n < 10; n++) push_fifo(c, n, 1'b0);
        for (int blk = 0; blk < 3; blk++)
            for (int c = 1; c <= 3; c++)
                for (int n = blk * 4; n < blk * 4 + 4 && n < 10; n++) sb.push_back(word(c, n));
        drain("rr_drain", 300);
        check_eq("rr_word_cnt", 64'(word_cnt), 30);
        check_eq("rr_grant_valid", 64'(grant_valid), 0);

        // Preempt while ch2 is mid-burst
        out_read = 1'b0;
        for (int n = 0; n < 10; n++) push_fifo(2, n, 1'b0);
        wait_cyc(2);
        check_eq("pre_grant_idx", 64'(grant_idx), 2);
        sb.push_back(word(2, 0));
        sb.push_back(word(2, 1));
        out_read = 1'b1;
        wait_cyc(2);
        preempt = 1'b1;
        for (int n = 0; n < 3; n++) push_fifo(0, n, 1'b0);
        for (int n = 0; n < 2; n++) push_fifo(1, n, 1'b0);
        #1;
        check_eq("pre_brk_empty", 64'(out_empty), 1);
        check_eq("pre_brk_no_pop", 64'(ch_read), 0);
        for (int n = 0; n < 3; n++) sb.push_back(word(0, n));
        for (int n = 0; n < 2; n++) sb.push_back(word(1, n));
        for (int n = 2; n < 10; n++) sb.push_back(word(2, n));
        drain("pre_drain", 300);
        preempt = 1'b0;
        check_eq("pre_word_cnt", 64'(word_cnt), 45);

        // ch1 disabled: never read, ch3 drained
        ch_en = 5'b11101;
        for (int n = 0; n < 3; n++) push_fifo(1, n, 1'b0);
        for (int n = 0; n < 4; n++) push_fifo(3, n, 1'b1);
        drain("en_drain", 200);
        check_eq("en_ch1_untouched", 64'(fq[1].size()), 3);
        check_eq("en_grant_valid", 64'(grant_valid), 0);
        check_eq("en_word_cnt", 64'(word_cnt), 49);
        fq[1].delete();
        ch_en = '1;
        refresh();

        // Reset in the middle of a ch1 burst
        out_read = 1'b0;
        for (int n = 0; n < 10; n++) push_fifo(1, n, 1'b0);
        sb.push_back(word(1, 0));
        sb.push_back(word(1, 1));
        wait_cyc(2);
        out_read = 1'b1;
        wait_cyc(2);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_out_empty", 64'(out_empty), 1);
        check_eq("mid_rst_ch_read", 64'(ch_read), 0);
        check_eq("mid_rst_grant_valid", 64'(grant_valid), 0);
        check_eq("mid_rst_word_cnt", 64'(word_cnt), 0);
        check_eq("mid_rst_out_data", 64'(out_data), 0);
        check_eq("mid_rst_sb", 64'(sb.size()), 0);
        push_fifo(0, 7, 1'b1);
        push_fifo(2, 7, 1'b0);
        for (int n = 2; n < 6; n++) sb.push_back(word(1, n));
        sb.push_back(word(2, 7));
        for (int n = 6; n < 10; n++) sb.push_back(word(1, n));
        wait_cyc(2);
        rst = 1'b0;
        drain("rst_drain", 200);
        check_eq("rst_word_cnt_after", 64'(word_cnt), 10);
        out_read = 1'b0;

        // Unlimited burst on ch4 with OUT_READ toggling
        b_total = 100;
        for (int n = 0; n < 100; n++) sb_b.push_back(32'hB000_0000 + 32'(n));
        refresh();
        for (int n = 0; n < 600 && sb_b.size() != 0; n++) begin
            b_out_read = ~b_out_read;
            wait_cyc();
        end
        b_out_read = 1'b0;
        check_eq("b_drain", 64'(sb_b.size()), 0);
        wait_cyc(4);
        check_eq("b_word_cnt", 64'(b_word_cnt), 100);
        check_eq("b_single_grant", 64'(b_grants), 1);
        check_eq("b_grant_valid_end", 64'(b_grant_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
